slowfil_tapctl: RTL

Coefficient-bank controller and sample scheduler for a reloadable-tap `slowfil_srl` instance (FIXED_TAPS=0). It holds NBANKS coefficient sets written over a simple port and streams a selected bank into the filter's tap-write interface on command. It paces incoming samples to the filter's one-sample-per-NTAPS-cycles rate and suppresses the stale outputs produced while the shift-register history refills after a reload.

---
 rtl/slowfil_pkg.sv | 18 +
 rtl/slowfil_tapctl_if.sv | 24 ++
 rtl/slowfil_coefmem.sv | 27 ++
 rtl/slowfil_tapctl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/slowfil_pkg.sv
// slowfil_pkg: shared state encoding and default geometry for the slowfil tap controller.
package slowfil_pkg;

    localparam int unsigned NTAPS_DEF  = 128;
    localparam int unsigned NBANKS_DEF = 4;
    localparam int unsigned LGNTAPS    = $clog2(NTAPS_DEF);
    localparam int unsigned LGBANK     = $clog2(NBANKS_DEF);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PREFETCH,
        LOAD,
        FLUSH,
        RUN
    } tapctl_state_t;

endpackage

// File: rtl/slowfil_tapctl_if.sv
// slowfil_tapctl_if: link between the tap controller (master) and a reloadable slowfil_srl (slave).
interface slowfil_tapctl_if #(
    parameter int unsigned IW = 12,
    parameter int unsigned TW = 12,
    parameter int unsigned OW = 2*IW+7
);
    logic          fil_reset;
    logic          fil_tap_wr;
    logic [TW-1:0] fil_tap;
    logic          fil_ce;
    logic [IW-1:0] fil_sample;
    logic          fil_res_ce;
    logic [OW-1:0] fil_result;

    modport master (
        output fil_reset, fil_tap_wr, fil_tap, fil_ce, fil_sample,
        input  fil_res_ce, fil_result
    );

    modport slave (
        input  fil_reset, fil_tap_wr, fil_tap, fil_ce, fil_sample,
        output fil_res_ce, fil_result
    );
endinterface

// File: rtl/slowfil_coefmem.sv
// slowfil_coefmem: NBANKS x NTAPS coefficient RAM, registered read, read-before-write on collision.
module slowfil_coefmem
    import slowfil_pkg::*;
#(
    parameter int unsigned NBANKS = 2**LGBANK,
    parameter int unsigned NTAPS  = 2**LGNTAPS,
    parameter int unsigned TW     = 12
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [$clog2(NBANKS)-1:0] i_wbank,
    input  logic [$clog2(NTAPS)-1:0]  i_waddr,
    input  logic [TW-1:0]             i_wdata,
    input  logic                      i_re,
    input  logic [$clog2(NBANKS)-1:0] i_rbank,
    input  logic [$clog2(NTAPS)-1:0]  i_raddr,
    output logic [TW-1:0]             o_rdata
);
    logic [TW-1:0] mem [NBANKS*NTAPS];

    always_ff @(posedge i_clk) begin
        if (i_we)
            mem[{i_wbank, i_waddr}] <= i_wdata;
        if (i_re)
            o_rdata <= mem[{i_rbank, i_raddr}];
    end
endmodule

// File: rtl/slowfil_tapctl.sv
// slowfil_tapctl: coefficient-bank reload sequencer and sample pacer for a reloadable slowfil_srl.
// Define SLOWFIL_TAPCTL_DROPCNT_EN to build the saturating dropped-sample counter.
module slowfil_tapctl
    import slowfil_pkg::*;
#(
    parameter int unsigned NTAPS  = NTAPS_DEF,
    parameter int unsigned IW     = 12,
    parameter int unsigned TW     = 12,
    parameter int unsigned OW     = 2*IW+7,
    parameter int unsigned NBANKS = NBANKS_DEF,
    parameter int unsigned MINGAP = NTAPS
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_cwr,
    input  logic [$clog2(NBANKS)-1:0] i_cbank,
    input  logic [$clog2(NTAPS)-1:0]  i_caddr,
    input  logic [TW-1:0]             i_cdata,
    input  logic                      i_load,
    input  logic [$clog2(NBANKS)-1:0] i_load_bank,
    output logic                      o_busy,
    output logic                      o_loaded,
    output logic [$clog2(NBANKS)-1:0] o_active_bank,
    input  logic                      i_ce,
    input  logic [IW-1:0]             i_sample,
    output logic                      o_ready,
    slowfil_tapctl_if.master          fil,
    output logic                      o_ce,
    output logic [OW-1:0]             o_result,
    output logic [15:0]               o_drop_count
);
    localparam int unsigned TAP_AW  = $clog2(NTAPS);
    localparam int unsigned BANK_AW = $clog2(NBANKS);
    localparam int unsigned GAP_W   = $clog2(MINGAP);

    tapctl_state_t        state, state_nxt;
    logic [TAP_AW-1:0]    tap_cnt;
    logic [TAP_AW-1:0]    flush_cnt;
    logic [BANK_AW-1:0]   load_bank;
    logic [GAP_W-1:0]     gap;
    logic                 rd_en;
    logic [TAP_AW-1:0]    rd_addr;
    logic [TW-1:0]        rdata;
    logic                 last_tap;
    logic                 accept;

    assign last_tap = (tap_cnt == TAP_AW'(NTAPS-1));
    // A load request in RUN takes priority, so the sample in that cycle is refused.
    assign o_ready  = (state == FLUSH || state == RUN) && (gap == '0) && !(state == RUN && i_load);
    assign accept   = i_ce && o_ready;
    assign fil.fil_tap = (state == LOAD) ? rdata : '0;

    slowfil_coefmem #(
        .NBANKS (NBANKS),
        .NTAPS  (NTAPS),
        .TW     (TW)
    ) u_coefmem (
        .i_clk   (i_clk),
        .i_we    (i_cwr),
        .i_wbank (i_cbank),
        .i_waddr (i_caddr),
        .i_wdata (i_cdata),
        .i_re    (rd_en),
        .i_rbank (load_bank),
        .i_raddr (rd_addr),
        .o_rdata (rdata)
    );

    always_comb begin
        state_nxt      = state;
        o_busy         = 1'b0;
        fil.fil_reset  = 1'b0;
        fil.fil_tap_wr = 1'b0;
        rd_en          = 1'b0;
        rd_addr        = '0;
        case (state)
            IDLE:     if (i_load) state_nxt = CLEAR;
            CLEAR: begin
                o_busy        = 1'b1;
                fil.fil_reset = 1'b1;
                state_nxt     = PREFETCH;
            end
            PREFETCH: begin
                o_busy    = 1'b1;
                rd_en     = 1'b1;
                state_nxt = LOAD;
            end
            // Read runs one tap ahead of the write to hide the RAM latency.
            LOAD: begin
                o_busy         = 1'b1;
                fil.fil_tap_wr = 1'b1;
                rd_en          = !last_tap;
                rd_addr        = tap_cnt + TAP_AW'(1);
                if (last_tap) state_nxt = FLUSH;
            end
            FLUSH: begin
                o_busy = 1'b1;
                if (fil.fil_res_ce && flush_cnt == TAP_AW'(NTAPS-1)) state_nxt = RUN;
            end
            RUN:      if (i_load) state_nxt = CLEAR;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            tap_cnt        <= '0;
            flush_cnt      <= '0;
            load_bank      <= '0;
            o_active_bank  <= '0;
            o_loaded       <= 1'b0;
            gap            <= '0;
            fil.fil_ce     <= 1'b0;
            fil.fil_sample <= '0;
            o_ce           <= 1'b0;
            o_result       <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE || state == RUN) && i_load)
                load_bank <= i_load_bank;
            tap_cnt <= (state == LOAD) ? tap_cnt + TAP_AW'(1) : '0;
            if (state != FLUSH)
                flush_cnt <= '0;
            else if (fil.fil_res_ce)
                flush_cnt <= flush_cnt + TAP_AW'(1);
            if (state == LOAD && last_tap) begin
                o_active_bank <= load_bank;
                o_loaded      <= 1'b1;
            end
            if (accept)
                gap <= GAP_W'(MINGAP-1);
            else if (gap != '0)
                gap <= gap - GAP_W'(1);
            fil.fil_ce <= accept;
            if (accept)
                fil.fil_sample <= i_sample;
            o_ce <= (state == RUN) && fil.fil_res_ce;
            if (state == RUN && fil.fil_res_ce)
                o_result <= fil.fil_result;
        end
    end

`ifdef SLOWFIL_TAPCTL_DROPCNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            drop_cnt <= '0;
        else if (i_ce && !o_ready && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end

    assign o_drop_count = drop_cnt;
`else
    assign o_drop_count = '0;
`endif
endmodule
